memory_copier: RTL and testbench
================================

MEMORY_COPIER -- requirements
Module: memory_copier

Interface
REQ-001 Parameter: N, default 8, data and address width in bits; memory depth 2**N words.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a transfer; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy (read src, write dst), 1 = fill (write pattern to dst).
REQ-006 src  input  N  copy source base address.
REQ-007 dst  input  N  destination base address.
REQ-008 len  input  N  word count; 0 = no transfer.
REQ-009 pattern  input  N  fill data word.
REQ-010 mem_read  input  N  memory read data; valid the cycle after the memory samples a read address with we=0.
REQ-011 mem_we  output  1  memory write enable.
REQ-012 mem_addr  output  N  memory address.
REQ-013 mem_write  output  N  memory write data.
REQ-014 busy  output  1  high while a transfer is in progress.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 count  output  N  words written by the current or most recent transfer.

Function
REQ-017 States: IDLE, RD, WR, FILL, DONE.
REQ-018 IDLE with start=1 at a posedge: latch src, dst, len, mode, pattern; clear count; set busy=1. Next state is RD if mode=0, FILL if mode=1, DONE if len=0.
REQ-019 In IDLE: mem_we=0 and busy=0, and start is ignored in every other state.
REQ-020 RD, word i: mem_we=0, mem_addr=(src+i) mod 2**N, then WR at the next posedge.
REQ-021 WR, word i: mem_we=1, mem_addr=(dst+i) mod 2**N, mem_write=mem_read (combinational pass-through).
REQ-022 At the WR posedge: count+1 and i+1. Next state is RD if i+1<len, else DONE.
REQ-023 Copy throughput is 2 cycles per word, so busy is high for 2*len cycles.
REQ-024 FILL, word i: mem_we=1, mem_addr=(dst+i) mod 2**N, mem_write=pattern latched at start.
REQ-025 In FILL, count increments every posedge; at i+1=len the next state is DONE.
REQ-026 Fill throughput is 1 cycle per word.
REQ-027 DONE: busy=0, done=1, mem_we=0, for exactly one cycle, then IDLE.
REQ-028 len=0: start to DONE directly, with no memory access and count=0.
REQ-029 Addresses wrap modulo 2**N. For example, dst=0xFE with len=3 writes 0xFE, 0xFF, 0x00.
REQ-030 Overlapping copy regions proceed strictly in ascending word order with no hazard protection; with dst=src+1, data propagates forward.
REQ-031 count holds its final value after DONE until the next accepted start.
REQ-032 Input changes on src, dst, len, mode and pattern during busy have no effect.
REQ-033 When not in WR, mem_write=0.

Reset
REQ-034 At a posedge with rst_n=0: state=IDLE, busy=0, done=0, count=0, mem_we=0, mem_addr=0, internal index=0.
REQ-035 Reset mid-transfer aborts at that edge. Words already written remain, no further writes occur, and done is not asserted.
REQ-036 rst_n has priority over start in the same cycle.

Verification
REQ-037 Fill: mode=1, dst=0x10, len=4, pattern=0xA5 -> mem[0x10..0x13]=0xA5, busy high 4 cycles, done pulse on the 5th cycle after start, count=4.
REQ-038 Copy: preload mem[0x10..0x13]=0x01,0x02,0x03,0x04; mode=0, src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]=0x01..0x04, busy high 8 cycles, count=4, source unchanged.
REQ-039 Wrap plus len=0: fill dst=0xFE, len=3, pattern=0x3C -> mem[0xFE], mem[0xFF], mem[0x00]=0x3C. Then start with len=0 -> done pulse the next cycle, mem_we never high, count=0.
REQ-040 Start while busy: pulse start with len=1 during a len=4 fill -> ignored, exactly 4 writes, one done pulse.
REQ-041 Reset mid-copy: copy len=8 from 0x00 to 0x40, rst_n=0 after the 3rd write -> mem[0x40..0x42] updated, mem[0x43..0x47] untouched, busy=0, count=0, no done pulse.

Source files
------------

// File: rtl/memory_copier.sv
// Memory copy/fill engine: copies len words src->dst (2 cycles/word)
// or fills len words at dst with a pattern (1 cycle/word).
module memory_copier #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] src,
  input  logic [N-1:0] dst,
  input  logic [N-1:0] len,
  input  logic [N-1:0] pattern,
  input  logic [N-1:0] mem_read,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_write,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    FILL,
    DONE
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] src_q, dst_q, len_q, pat_q;
  logic [N-1:0] idx_q, idx_nxt;

  // idx doubles as the word count: it advances once per written word
  assign idx_nxt = idx_q + ONE;
  assign count   = idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        src_q <= src;
        dst_q <= dst;
        len_q <= len;
        pat_q <= pattern;
        idx_q <= '0;
      end else if (state_q == WR || state_q == FILL) begin
        idx_q <= idx_nxt;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_write = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) state_d = DONE;
          else if (mode) state_d = FILL;
          else           state_d = RD;
        end
      end
      RD: begin
        busy     = 1'b1;
        mem_addr = src_q + idx_q;
        state_d  = WR;
      end
      WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_q + idx_q;
        mem_write = mem_read;
        state_d   = (idx_nxt == len_q) ? DONE : RD;
      end
      FILL: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_q + idx_q;
        mem_write = pat_q;
        state_d   = (idx_nxt == len_q) ? DONE : FILL;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_copier.sv
// Scoreboard bench for memory_copier: expected writes are queued by
// stimulus and matched by a monitor watching mem_we.
module tb_memory_copier;

  logic       clk = 1'b0;
  logic       rst_n, start, mode;
  logic [7:0] src, dst, len, pattern, mem_rd;
  logic       mem_we, busy, done;
  logic [7:0] mem_addr, mem_write, count;

  memory_copier #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .pattern   (pattern),
    .mem_read  (mem_rd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_write;
    mem_rd = mem[mem_addr];
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  busy_cycles = 0;
  int  done_cnt = 0;
  int  we_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (mem_we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_write: got addr %0h data %0h expected none",
                   mem_addr, mem_write);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", int'(mem_addr), int'(e.a));
          chk("wr_data", int'(mem_write), int'(e.d));
        end
      end
    end
  end

  task automatic do_start(input logic m, input logic [7:0] s,
                          input logic [7:0] d, input logic [7:0] l,
                          input logic [7:0] p);
    @(posedge clk);
    #1;
    busy_cycles = 0;
    done_cnt    = 0;
    we_cnt      = 0;
    mode    = m;
    src     = s;
    dst     = d;
    len     = l;
    pattern = p;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk(nm, lat, exp_lat);
    @(negedge clk);
    chk("done_pulse_len", int'(done), 0);
    @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    start = 1'b1;
    mode = 1'b1;
    src = 8'h00;
    dst = 8'h10;
    len = 8'h04;
    pattern = 8'hFF;

    // reset holds even with start asserted
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_addr", int'(mem_addr), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;

    // fill
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 8'hA5);
    do_start(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5);
    wait_done("fill_lat", 5);
    chk("fill_busy", busy_cycles, 4);
    chk("fill_count", int'(count), 4);
    chk("fill_q", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) chk("fill_mem", int'(mem[8'h10 + i]), 8'hA5);

    // copy
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) push(8'h80 + 8'(i), 8'(i + 1));
    do_start(1'b0, 8'h10, 8'h80, 8'd4, 8'h00);
    wait_done("copy_lat", 9);
    chk("copy_busy", busy_cycles, 8);
    chk("copy_count", int'(count), 4);
    chk("copy_q", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) chk("copy_dst", int'(mem[8'h80 + i]), i + 1);
    for (int i = 0; i < 4; i++) chk("copy_src", int'(mem[8'h10 + i]), i + 1);

    // wrap fill
    push(8'hFE, 8'h3C);
    push(8'hFF, 8'h3C);
    push(8'h00, 8'h3C);
    do_start(1'b1, 8'h00, 8'hFE, 8'd3, 8'h3C);
    wait_done("wrap_lat", 4);
    chk("wrap_count", int'(count), 3);
    chk("wrap_q", exp_q.size(), 0);
    chk("wrap_mem00", int'(mem[0]), 8'h3C);
    chk("wrap_memff", int'(mem[255]), 8'h3C);

    // len = 0
    do_start(1'b1, 8'h00, 8'h50, 8'd0, 8'h77);
    wait_done("len0_lat", 1);
    chk("len0_we", we_cnt, 0);
    chk("len0_busy", busy_cycles, 0);
    chk("len0_count", int'(count), 0);

    // start and input changes while busy are ignored
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 8'h5A);
    do_start(1'b1, 8'h00, 8'h20, 8'd4, 8'h5A);
    fork
      begin
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = 1'b0;
        dst = 8'h70;
        len = 8'd1;
        pattern = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join_none
    wait_done("busy_lat", 5);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_we", we_cnt, 4);
    chk("busy_done", done_cnt, 1);
    chk("busy_busy", busy_cycles, 4);
    chk("busy_count", int'(count), 4);
    chk("busy_q", exp_q.size(), 0);
    chk("busy_mem70", int'(mem[8'h70]), 0);

    // overlapping copy: dst = src + 1 propagates forward
    mem[8'h30] = 8'h11;
    mem[8'h31] = 8'h22;
    mem[8'h32] = 8'h33;
    mem[8'h33] = 8'h44;
    push(8'h31, 8'h11);
    push(8'h32, 8'h11);
    push(8'h33, 8'h11);
    do_start(1'b0, 8'h30, 8'h31, 8'd3, 8'h00);
    wait_done("ovl_lat", 7);
    chk("ovl_q", exp_q.size(), 0);
    chk("ovl_mem33", int'(mem[8'h33]), 8'h11);

    // reset mid-copy after the 3rd write
    for (int i = 0; i < 8; i++) mem[i] = 8'h80 + 8'(i);
    for (int i = 0; i < 8; i++) mem[8'h40 + i] = 8'hEE;
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 8'h80 + 8'(i));
    do_start(1'b0, 8'h00, 8'h40, 8'd8, 8'h00);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk);
        if (we_cnt == 3) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rst_wait", int'(seen), 1);
    end
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(count), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_done", done_cnt, 0);
    chk("abort_we", we_cnt, 3);
    chk("abort_q", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) chk("abort_wr", int'(mem[8'h40 + i]), 8'h80 + i);
    for (int i = 3; i < 8; i++) chk("abort_keep", int'(mem[8'h40 + i]), 8'hEE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
